// File: rtl/timer_tick_scheduler_pkg.sv
// Shared definitions for the timer tick scheduler: interval-timer register
// map, control-register bit positions, and the scheduler state encoding.
package timer_sched_pkg;

  // Interval timer register addresses (16-bit register slave)
  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  // Control register bit positions
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  // Control words written by the scheduler
  localparam logic [15:0] CTRL_RUN_WORD  = 16'((32'd1 << START) | (32'd1 << CONT) | (32'd1 << ITO));
  localparam logic [15:0] CTRL_STOP_WORD = 16'(32'd1 << STOP);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_PL   = 3'd1,
    S_WR_PH   = 3'd2,
    S_WR_CTRL = 3'd3,
    S_RUN     = 3'd4,
    S_CLR     = 3'd5,
    S_GUARD   = 3'd6,
    S_WR_STOP = 3'd7
  } sched_state_e;

endpackage

// File: rtl/timer_tick_scheduler_if.sv
// Avalon-MM write-only link between the scheduler (master) and the
// interval timer slave, plus the timer's level interrupt.
interface timer_tick_scheduler_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest;
  logic        timer_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_waitrequest, timer_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_waitrequest, timer_irq
  );
endinterface

// File: rtl/timer_tick_scheduler_channel.sv
// One software-style countdown channel driven by the system tick.
// A count of 0 or 1 expires on the next tick; arm beats disarm, and
// both beat the tick in the same cycle.
module tick_channel #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              arm,
  input  logic [TICK_W-1:0] load,
  input  logic              periodic,
  input  logic              disarm,
  input  logic              ack,
  output logic              expire,
  output logic              pending
);

  logic [TICK_W-1:0] cnt_r, cnt_s;
  logic [TICK_W-1:0] reload_r, reload_s;
  logic              periodic_r, periodic_s;
  logic              active_r, active_s;
  logic              pending_r, pending_s;
  logic              expire_r, expire_s;

  // Next channel state: arm, then disarm, then tick, in priority order
  always_comb begin
    cnt_s      = cnt_r;
    reload_s   = reload_r;
    periodic_s = periodic_r;
    active_s   = active_r;
    expire_s   = 1'b0;
    // an expiry in the same cycle re-sets pending below, so ack loses
    pending_s  = pending_r & ~ack;
    if (arm) begin
      cnt_s      = load;
      reload_s   = load;
      periodic_s = periodic;
      active_s   = 1'b1;
    end else if (disarm) begin
      active_s = 1'b0;
    end else if (tick && active_r) begin
      if (cnt_r <= TICK_W'(1)) begin
        expire_s  = 1'b1;
        pending_s = 1'b1;
        if (periodic_r) begin
          cnt_s = reload_r;
        end else begin
          active_s = 1'b0;
        end
      end else begin
        cnt_s = cnt_r - TICK_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= '0;
      reload_r   <= '0;
      periodic_r <= 1'b0;
      active_r   <= 1'b0;
      pending_r  <= 1'b0;
      expire_r   <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      reload_r   <= reload_s;
      periodic_r <= periodic_s;
      active_r   <= active_s;
      pending_r  <= pending_s;
      expire_r   <= expire_s;
    end
  end

  assign expire  = expire_r;
  assign pending = pending_r;

endmodule

// File: rtl/timer_tick_scheduler.sv
// Programs the interval timer over Avalon-MM, services each timeout into a
// single-cycle tick plus a running tick count, and fans the tick out to
// NUM_CH countdown channels.
module timer_tick_scheduler
  import timer_sched_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          TICK_W         = 16,
  parameter logic [31:0] PERIOD_DEFAULT = 32'd99999
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic [31:0]              cfg_period,
  output logic                     running,
  timer_tick_scheduler_if.master   avm,
  output logic                     tick,
  output logic [31:0]              tick_count,
  input  logic [NUM_CH-1:0]        ch_arm,
  input  logic [NUM_CH*TICK_W-1:0] ch_load,
  input  logic [NUM_CH-1:0]        ch_periodic,
  input  logic [NUM_CH-1:0]        ch_disarm,
  input  logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_expire,
  output logic [NUM_CH-1:0]        ch_pending
);

  sched_state_e state_r, state_s;
  logic [31:0]  period_r, period_s;
  logic         stop_req_r, stop_req_s;

  logic         cs_r, cs_s;
  logic         write_n_r, write_n_s;
  logic [2:0]   addr_r, addr_s;
  logic [15:0]  data_r, data_s;
  logic         running_r, running_s;
  logic         tick_r;
  logic [31:0]  tick_count_r;

  logic         start_acc_s;
  logic         clr_done_s;

  assign start_acc_s = (state_r == S_IDLE) && cfg_start;
  assign clr_done_s  = (state_r == S_CLR) && !avm.avm_waitrequest;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      period_r     <= 32'd0;
      stop_req_r   <= 1'b0;
      cs_r         <= 1'b0;
      write_n_r    <= 1'b1;
      addr_r       <= 3'd0;
      data_r       <= 16'd0;
      running_r    <= 1'b0;
      tick_r       <= 1'b0;
      tick_count_r <= 32'd0;
    end else begin
      state_r    <= state_s;
      period_r   <= period_s;
      stop_req_r <= stop_req_s;
      cs_r       <= cs_s;
      write_n_r  <= write_n_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      running_r  <= running_s;
      tick_r     <= clr_done_s;
      if (start_acc_s) begin
        tick_count_r <= 32'd0;
      end else if (clr_done_s) begin
        tick_count_r <= tick_count_r + 32'd1;
      end else begin
        tick_count_r <= tick_count_r;
      end
    end
  end

  // Next-state logic; every write state waits for waitrequest to drop
  always_comb begin
    state_s    = state_r;
    period_s   = period_r;
    stop_req_s = stop_req_r;
    case (state_r)
      S_IDLE: begin
        stop_req_s = 1'b0;
        if (cfg_start) begin
          period_s = (cfg_period == 32'd0) ? PERIOD_DEFAULT : cfg_period;
          state_s  = S_WR_PL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR_PL: begin
        if (!avm.avm_waitrequest) state_s = S_WR_PH;
        else                      state_s = S_WR_PL;
      end
      S_WR_PH: begin
        if (!avm.avm_waitrequest) state_s = S_WR_CTRL;
        else                      state_s = S_WR_PH;
      end
      S_WR_CTRL: begin
        if (!avm.avm_waitrequest) state_s = S_RUN;
        else                      state_s = S_WR_CTRL;
      end
      S_RUN: begin
        // a pending timeout is serviced before a stop request
        if (avm.timer_irq) begin
          state_s    = S_CLR;
          stop_req_s = cfg_stop;
        end else if (cfg_stop) begin
          state_s = S_WR_STOP;
        end else begin
          state_s = S_RUN;
        end
      end
      S_CLR: begin
        if (cfg_stop) stop_req_s = 1'b1;
        else          stop_req_s = stop_req_r;
        if (!avm.avm_waitrequest) state_s = S_GUARD;
        else                      state_s = S_CLR;
      end
      S_GUARD: begin
        // irq is deliberately ignored here: its deassert lags the clear write
        stop_req_s = 1'b0;
        if (stop_req_r || cfg_stop) state_s = S_WR_STOP;
        else                        state_s = S_RUN;
      end
      S_WR_STOP: begin
        if (!avm.avm_waitrequest) state_s = S_IDLE;
        else                      state_s = S_WR_STOP;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Bus and status outputs for the upcoming state, registered above
  always_comb begin
    cs_s      = 1'b0;
    write_n_s = 1'b1;
    addr_s    = TMR_STATUS;
    data_s    = 16'd0;
    running_s = 1'b0;
    case (state_s)
      S_WR_PL: begin
        cs_s = 1'b1; write_n_s = 1'b0;
        addr_s = TMR_PERIODL; data_s = period_s[15:0];
      end
      S_WR_PH: begin
        cs_s = 1'b1; write_n_s = 1'b0;
        addr_s = TMR_PERIODH; data_s = period_s[31:16];
      end
      S_WR_CTRL: begin
        cs_s = 1'b1; write_n_s = 1'b0;
        addr_s = TMR_CONTROL; data_s = CTRL_RUN_WORD;
      end
      S_RUN: begin
        running_s = 1'b1;
      end
      S_CLR: begin
        cs_s = 1'b1; write_n_s = 1'b0;
        addr_s = TMR_STATUS; data_s = 16'd0;
        running_s = 1'b1;
      end
      S_WR_STOP: begin
        cs_s = 1'b1; write_n_s = 1'b0;
        addr_s = TMR_CONTROL; data_s = CTRL_STOP_WORD;
      end
      default: begin
        cs_s = 1'b0;
      end
    endcase
  end

  assign avm.avm_address    = addr_r;
  assign avm.avm_chipselect = cs_r;
  assign avm.avm_write_n    = write_n_r;
  assign avm.avm_writedata  = data_r;
  assign running            = running_r;
  assign tick               = tick_r;
  assign tick_count         = tick_count_r;

  // Channels advance on the same edge that raises tick
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(.TICK_W(TICK_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (clr_done_s),
      .arm      (ch_arm[g]),
      .load     (ch_load[g*TICK_W +: TICK_W]),
      .periodic (ch_periodic[g]),
      .disarm   (ch_disarm[g]),
      .ack      (ch_ack[g]),
      .expire   (ch_expire[g]),
      .pending  (ch_pending[g])
    );
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler with a transaction-level model:
// expected Avalon writes are queued by the stimulus, ticks follow each
// completed status clear, and channels are modelled as ticks-left counters.
module tb_timer_tick_scheduler;
  localparam int NUM_CH = 4;
  localparam int TICK_W = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     cfg_start, cfg_stop;
  logic [31:0]              cfg_period;
  logic                     running, tick;
  logic [31:0]              tick_count;
  logic [NUM_CH-1:0]        ch_arm, ch_periodic, ch_disarm, ch_ack;
  logic [NUM_CH*TICK_W-1:0] ch_load;
  logic [NUM_CH-1:0]        ch_expire, ch_pending;

  timer_tick_scheduler_if bus();

  timer_tick_scheduler #(.NUM_CH(NUM_CH), .TICK_W(TICK_W), .PERIOD_DEFAULT(32'd99999)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .running(running), .avm(bus), .tick(tick),
    .tick_count(tick_count), .ch_arm(ch_arm), .ch_load(ch_load),
    .ch_periodic(ch_periodic), .ch_disarm(ch_disarm), .ch_ack(ch_ack),
    .ch_expire(ch_expire), .ch_pending(ch_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [2:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model state (owned by the monitor) ----------------
  logic              m_tick;
  logic [31:0]       m_cnt;
  logic [NUM_CH-1:0] m_exp, m_pend;
  bit                m_idle;
  int                left_t [NUM_CH];
  int                rel_t  [NUM_CH];
  bit                act_t  [NUM_CH];
  bit                per_t  [NUM_CH];
  bit                prev_stall;
  logic [20:0]       prev_bus;

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    bit  done, tick_ev;
    wr_t e;
    int  ld;
    if (reset) begin
      m_tick = 1'b0; m_cnt = 32'd0; m_exp = '0; m_pend = '0; m_idle = 1'b1;
      prev_stall = 1'b0;
      for (int i = 0; i < NUM_CH; i++) act_t[i] = 1'b0;
    end else begin
      chk("tick", {63'd0, tick}, {63'd0, m_tick});
      chk("tick_count", {32'd0, tick_count}, {32'd0, m_cnt});
      chk("ch_expire", {60'd0, ch_expire}, {60'd0, m_exp});
      chk("ch_pending", {60'd0, ch_pending}, {60'd0, m_pend});
      if (prev_stall)
        chk("stall_hold", {43'd0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata},
            {43'd0, prev_bus});
      done = bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest;
      tick_ev = 1'b0;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", bus.avm_address, bus.avm_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {61'd0, bus.avm_address}, {61'd0, e.a});
          chk("wr_data", {48'd0, bus.avm_writedata}, {48'd0, e.d});
          tick_ev = (e.a == 3'd0);
          if (e.a == 3'd1 && e.d == 16'h0008) m_idle = 1'b1;
        end
      end
      prev_stall = bus.avm_chipselect && bus.avm_waitrequest;
      prev_bus   = {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata};
      // expectations for the next cycle
      if (cfg_start && m_idle) begin
        m_cnt = 32'd0; m_idle = 1'b0;
      end else if (tick_ev) begin
        m_cnt = m_cnt + 32'd1;
      end
      m_tick = tick_ev;
      for (int i = 0; i < NUM_CH; i++) begin
        m_exp[i] = 1'b0;
        if (ch_ack[i]) m_pend[i] = 1'b0;
        if (ch_arm[i]) begin
          ld = int'(ch_load[i*TICK_W +: TICK_W]);
          left_t[i] = (ld == 0) ? 1 : ld;
          rel_t[i]  = left_t[i];
          per_t[i]  = ch_periodic[i];
          act_t[i]  = 1'b1;
        end else if (ch_disarm[i]) begin
          act_t[i] = 1'b0;
        end else if (tick_ev && act_t[i]) begin
          left_t[i]--;
          if (left_t[i] == 0) begin
            m_exp[i] = 1'b1; m_pend[i] = 1'b1;
            if (per_t[i]) left_t[i] = rel_t[i];
            else          act_t[i] = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [31:0] p);
    logic [31:0] pe;
    pe = (p == 32'd0) ? 32'd99999 : p;
    exp_q.push_back('{3'd2, pe[15:0]});
    exp_q.push_back('{3'd3, pe[31:16]});
    exp_q.push_back('{3'd1, 16'h0007});
    cfg_period = p; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic chk_bus(input string nm, input logic [2:0] a, input logic [15:0] d);
    chk({nm, "_cs_wn"}, {62'd0, bus.avm_chipselect, bus.avm_write_n}, 64'd2);
    chk({nm, "_addr"}, {61'd0, bus.avm_address}, {61'd0, a});
    chk({nm, "_data"}, {48'd0, bus.avm_writedata}, {48'd0, d});
  endtask

  // One serviced timeout; channel inputs are presented in the clear cycle
  task automatic do_tick(input logic [NUM_CH-1:0] ack, input logic [NUM_CH-1:0] arm,
                         input logic [NUM_CH*TICK_W-1:0] ld, input logic [NUM_CH-1:0] per,
                         input logic [NUM_CH-1:0] dis, input bit stop);
    int n;
    exp_q.push_back('{3'd0, 16'h0000});
    if (stop) exp_q.push_back('{3'd1, 16'h0008});
    bus.timer_irq = 1'b1; cfg_stop = stop;
    step();
    cfg_stop = 1'b0;
    ch_ack = ack; ch_arm = arm; ch_load = ld; ch_periodic = per; ch_disarm = dis;
    step();
    ch_ack = '0; ch_arm = '0; ch_disarm = '0;
    n = 0;
    while (!tick && n < 8) begin step(); n++; end
    chk("tick_seen", {63'd0, tick}, 64'd1);
    step();                  // irq held through the guard cycle
    bus.timer_irq = 1'b0;
    step(); step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_period = 32'd0;
    ch_arm = '0; ch_load = '0; ch_periodic = '0; ch_disarm = '0; ch_ack = '0;
    bus.avm_waitrequest = 1'b0; bus.timer_irq = 1'b0;
    step(); step();
    chk_bus_idle: begin
      chk("rst_cs_wn", {62'd0, bus.avm_chipselect, bus.avm_write_n}, 64'd1);
      chk("rst_addr_data", {45'd0, bus.avm_address, bus.avm_writedata}, 64'd0);
      chk("rst_tick_run", {62'd0, tick, running}, 64'd0);
      chk("rst_count", {32'd0, tick_count}, 64'd0);
      chk("rst_ch", {56'd0, ch_expire, ch_pending}, 64'd0);
    end
    reset = 1'b0;
    step();

    // arm ch0 load 2 periodic, ch1 load 0 one-shot, ch3 load 3 periodic
    ch_arm = 4'b1011; ch_periodic = 4'b1001;
    ch_load = {16'd3, 16'd0, 16'd0, 16'd2};
    step();
    ch_arm = '0;
    chk("arm_no_pending", {60'd0, ch_pending}, 64'd0);

    // default period, no stalls: three consecutive writes then RUN
    start(32'd0);
    chk_bus("pl", 3'd2, 16'h869F); step();
    chk_bus("ph", 3'd3, 16'h0001); step();
    chk_bus("ctrl", 3'd1, 16'h0007); step();
    chk("run_after_start", {62'd0, running, bus.avm_chipselect}, 64'd2);
    step();

    do_tick(4'b0000, 4'b0000, ch_load, 4'b0000, 4'b0000, 1'b0);
    chk("pend_t1", {60'd0, ch_pending}, 64'h2);
    // arm ch2 load 1 one-shot together with tick 2: no expiry on tick 2
    do_tick(4'b0000, 4'b0100, {16'd3, 16'd1, 16'd0, 16'd2}, 4'b1001, 4'b0000, 1'b0);
    chk("pend_t2", {60'd0, ch_pending}, 64'h3);
    do_tick(4'b0010, 4'b0000, ch_load, 4'b1001, 4'b0000, 1'b0);
    chk("count_3", {32'd0, tick_count}, 64'd3);
    chk("pend_t3", {60'd0, ch_pending}, 64'hD);
    // ack ch0 coincident with its expiry; disarm ch3 on the same tick
    do_tick(4'b0001, 4'b0000, ch_load, 4'b1001, 4'b1000, 1'b0);
    chk("pend_t4", {60'd0, ch_pending}, 64'hD);
    ch_ack = 4'b1101; step(); ch_ack = '0; step();
    chk("pend_acked", {60'd0, ch_pending}, 64'h0);
    do_tick(4'b0000, 4'b0000, ch_load, 4'b1001, 4'b0000, 1'b0);
    do_tick(4'b0000, 4'b0000, ch_load, 4'b1001, 4'b0000, 1'b0);
    chk("pend_t6", {60'd0, ch_pending}, 64'h1);
    chk("count_6", {32'd0, tick_count}, 64'd6);

    // stop together with irq: clear and tick first, then stop write
    do_tick(4'b0000, 4'b0000, ch_load, 4'b1001, 4'b0000, 1'b1);
    step();
    chk("stopped", {62'd0, running, bus.avm_chipselect}, 64'd0);
    chk("count_held", {32'd0, tick_count}, 64'd7);

    // stop while idle does nothing
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0; step(); step();
    chk("idle_stop", {62'd0, running, bus.avm_chipselect}, 64'd0);

    // restart with explicit period and a 3-cycle stall on the high write
    start(32'h0002_0003);
    chk_bus("pl2", 3'd2, 16'h0003);
    chk("count_cleared", {32'd0, tick_count}, 64'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      bus.avm_waitrequest = (k < 3);
      chk_bus("ph_stall", 3'd3, 16'h0002);
      step();
    end
    bus.avm_waitrequest = 1'b0;
    chk_bus("ctrl2", 3'd1, 16'h0007); step();
    chk("run2", {63'd0, running}, 64'd1);

    // start while running is ignored
    cfg_start = 1'b1; step(); cfg_start = 1'b0; step();
    chk("start_ignored", {63'd0, bus.avm_chipselect}, 64'd0);
    do_tick(4'b0000, 4'b0000, ch_load, 4'b1001, 4'b0000, 1'b0);
    chk("count_1", {32'd0, tick_count}, 64'd1);

    // plain stop
    exp_q.push_back('{3'd1, 16'h0008});
    cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
    chk_bus("stopw", 3'd1, 16'h0008);
    step(); step();
    chk("stopped2", {62'd0, running, bus.avm_chipselect}, 64'd0);

    // reset in the middle of the period-high write
    start(32'd0); step();
    chk_bus("ph3", 3'd3, 16'h0001);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_cs_wn", {62'd0, bus.avm_chipselect, bus.avm_write_n}, 64'd1);
    chk("rst_mid_state", {31'd0, running, tick_count}, 64'd0);
    chk("rst_mid_pend", {60'd0, ch_pending}, 64'd0);
    step(); reset = 1'b0; step(); step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
